// File: rtl/raster_stamp_packer.sv
// raster_stamp_packer
// -----------------------------------------------------------------------------
// Serves one raster fetch request at a time. For the requesting warp it pulls
// stamps from the raster output stream, one per active lane in ascending lane
// order, then issues a single write of the gathered stamps into the per-warp
// raster CSR store and returns a per-lane success result.
//
// Optional feature: define RASTER_PACKER_PERF_EN to add two 32-bit performance
// counters (perf_stall_cycles, perf_fetches). Without the macro the ports and
// counters do not exist and behaviour is otherwise identical.
//
// Ports
//   clk, reset           clock; synchronous active-low reset
//   req_*                fetch request (valid/ready), warp id, lane mask, uuid
//   stamp_*              raster stamp stream (valid/ready), payload, and the
//                        level-sensitive "no more stamps" flag stamp_done
//   csr_write_*          one-cycle write strobe and payload into the CSR store;
//                        lane i of csr_write_data is [i*STAMP_W +: STAMP_W]
//   rsp_*                per-thread result (valid/ready); lane i of rsp_data is
//                        1 when that lane received a stamp
//   perf_*               (RASTER_PACKER_PERF_EN only) stall / fetch counters
//
// Handshake semantics (all valid/ready pairs): a transfer happens on a rising
// clk edge where valid and ready are both 1. A producer keeps valid and its
// payload stable until that transfer; ready may be raised or dropped freely.
// -----------------------------------------------------------------------------
module raster_stamp_packer #(
    parameter int CORE_ID     = 0,
    parameter int NUM_THREADS = 4,
    parameter int NUM_WARPS   = 4,
    parameter int STAMP_W     = 64,
    parameter int UUID_W      = 44,
    localparam int NW_W       = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                         clk,
    input  logic                         reset,

    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [NW_W-1:0]              req_wid,
    input  logic [NUM_THREADS-1:0]       req_tmask,
    input  logic [UUID_W-1:0]            req_uuid,

    input  logic                         stamp_valid,
    output logic                         stamp_ready,
    input  logic [STAMP_W-1:0]           stamp_data,
    input  logic                         stamp_done,

    output logic                         csr_write_enable,
    output logic [UUID_W-1:0]            csr_write_uuid,
    output logic [NW_W-1:0]              csr_write_wid,
    output logic [NUM_THREADS-1:0]       csr_write_tmask,
    output logic [NUM_THREADS*STAMP_W-1:0] csr_write_data,

`ifdef RASTER_PACKER_PERF_EN
    output logic [31:0]                  perf_stall_cycles,
    output logic [31:0]                  perf_fetches,
`endif

    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [NW_W-1:0]              rsp_wid,
    output logic [UUID_W-1:0]            rsp_uuid,
    output logic [NUM_THREADS-1:0]       rsp_tmask,
    output logic [NUM_THREADS*32-1:0]    rsp_data
);

    // CORE_ID only tags debug traces; a negative value is meaningless.
    if (CORE_ID < 0) begin : g_core_id_invalid
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GATHER = 2'd1,
        WRITE  = 2'd2,
        RESP   = 2'd3
    } state_e;

    // FSM state is kept in a named enum register so checkers can bind to it.
    state_e                   state_q;
    state_e                   state_d;

    // live_q holds req_ready low for the first cycle after reset release.
    logic                     live_q;

    logic [NW_W-1:0]          wid_q;
    logic [UUID_W-1:0]        uuid_q;
    logic [NUM_THREADS-1:0]   tmask_q;
    logic [NUM_THREADS-1:0]   pending_q;
    logic [NUM_THREADS-1:0]   pending_d;
    logic [NUM_THREADS-1:0]   filled_q;
    logic [NUM_THREADS-1:0]   filled_d;
    logic [STAMP_W-1:0]       lane_q [NUM_THREADS];

    logic [NUM_THREADS-1:0]   pick;
    logic                     req_fire;
    logic                     stamp_fire;

    // One-hot of the lowest still-pending lane: the lane the next stamp fills.
    assign pick       = pending_q & (-pending_q);
    assign req_fire   = req_valid && req_ready;
    assign stamp_fire = stamp_valid && stamp_ready;

    // ------------------------------------------------------------------
    // Next-state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d          = state_q;
        pending_d        = pending_q;
        filled_d         = filled_q;
        req_ready        = 1'b0;
        stamp_ready      = 1'b0;
        csr_write_enable = 1'b0;
        rsp_valid        = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = live_q;
                if (req_valid && live_q) begin
                    pending_d = req_tmask;
                    filled_d  = '0;
                    state_d   = (req_tmask == '0) ? WRITE : GATHER;
                end
            end

            GATHER: begin
                stamp_ready = 1'b1;
                // A present stamp always wins over stamp_done in the same
                // cycle; done is looked at again once valid drops.
                if (stamp_valid) begin
                    pending_d = pending_q & ~pick;
                    filled_d  = filled_q | pick;
                    if ((pending_q & ~pick) == '0) begin
                        state_d = WRITE;
                    end
                end else if (stamp_done) begin
                    state_d = WRITE;
                end
            end

            WRITE: begin
                // Nothing gathered means nothing to store: skip the strobe.
                csr_write_enable = (filled_q != '0);
                state_d          = RESP;
            end

            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            live_q    <= 1'b0;
            pending_q <= '0;
            filled_q  <= '0;
            wid_q     <= '0;
            uuid_q    <= '0;
            tmask_q   <= '0;
            for (int i = 0; i < NUM_THREADS; i++) begin
                lane_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            live_q    <= 1'b1;
            pending_q <= pending_d;
            filled_q  <= filled_d;
            if (req_fire) begin
                wid_q   <= req_wid;
                uuid_q  <= req_uuid;
                tmask_q <= req_tmask;
            end
            if (stamp_fire) begin
                for (int i = 0; i < NUM_THREADS; i++) begin
                    if (pick[i]) begin
                        lane_q[i] <= stamp_data;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // CSR write payload: only meaningful while the strobe is high, and
    // lanes that were not filled are driven to zero.
    // ------------------------------------------------------------------
    always_comb begin
        csr_write_uuid  = '0;
        csr_write_wid   = '0;
        csr_write_tmask = '0;
        csr_write_data  = '0;
        if (csr_write_enable) begin
            csr_write_uuid  = uuid_q;
            csr_write_wid   = wid_q;
            csr_write_tmask = filled_q;
            for (int i = 0; i < NUM_THREADS; i++) begin
                if (filled_q[i]) begin
                    csr_write_data[i*STAMP_W +: STAMP_W] = lane_q[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Response payload: held from registers, so stable while rsp_valid is
    // high and rsp_ready is low.
    // ------------------------------------------------------------------
    always_comb begin
        rsp_wid   = '0;
        rsp_uuid  = '0;
        rsp_tmask = '0;
        rsp_data  = '0;
        if (rsp_valid) begin
            rsp_wid   = wid_q;
            rsp_uuid  = uuid_q;
            rsp_tmask = tmask_q;
            for (int i = 0; i < NUM_THREADS; i++) begin
                rsp_data[i*32 +: 32] = {31'b0, filled_q[i]};
            end
        end
    end

`ifdef RASTER_PACKER_PERF_EN
    // ------------------------------------------------------------------
    // Performance counters (wrap modulo 2^32)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_stall_cycles <= '0;
            perf_fetches      <= '0;
        end else begin
            if (state_q == GATHER && !stamp_valid && !stamp_done) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if (req_fire) begin
                perf_fetches <= perf_fetches + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_raster_stamp_packer.sv
// Testbench for raster_stamp_packer (default parameters).
// Stimulus is driven 2 time units after the rising edge; DUT outputs are
// observed on the falling edge. A stamp source process feeds stamps from a
// queue with optional random gaps, and a monitor logs every strobe, response
// and handshake with its cycle number. Expected values come from a lane-order
// reference model of the gather.
module tb_raster_stamp_packer;
  localparam int NT  = 4;
  localparam int SW  = 64;
  localparam int UW  = 44;
  localparam int NWW = 2;
  localparam int TO  = 200;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [NWW-1:0] req_wid = '0;
  logic [NT-1:0] req_tmask = '0;
  logic [UW-1:0] req_uuid = '0;
  logic stamp_valid = 1'b0;
  logic stamp_ready;
  logic [SW-1:0] stamp_data = '0;
  logic stamp_done = 1'b0;
  logic csr_write_enable;
  logic [UW-1:0] csr_write_uuid;
  logic [NWW-1:0] csr_write_wid;
  logic [NT-1:0] csr_write_tmask;
  logic [NT*SW-1:0] csr_write_data;
  logic rsp_valid;
  logic rsp_ready = 1'b1;
  logic [NWW-1:0] rsp_wid;
  logic [UW-1:0] rsp_uuid;
  logic [NT-1:0] rsp_tmask;
  logic [NT*32-1:0] rsp_data;
`ifdef RASTER_PACKER_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_fetches;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  raster_stamp_packer dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wid(req_wid),
    .req_tmask(req_tmask), .req_uuid(req_uuid),
    .stamp_valid(stamp_valid), .stamp_ready(stamp_ready),
    .stamp_data(stamp_data), .stamp_done(stamp_done),
    .csr_write_enable(csr_write_enable), .csr_write_uuid(csr_write_uuid),
    .csr_write_wid(csr_write_wid), .csr_write_tmask(csr_write_tmask),
    .csr_write_data(csr_write_data),
`ifdef RASTER_PACKER_PERF_EN
    .perf_stall_cycles(perf_stall_cycles), .perf_fetches(perf_fetches),
`endif
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wid(rsp_wid),
    .rsp_uuid(rsp_uuid), .rsp_tmask(rsp_tmask), .rsp_data(rsp_data)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- monitor ----------------
  int wr_cyc_q[$];
  logic [NT-1:0] wr_tmask_q[$];
  logic [NT*SW-1:0] wr_data_q[$];
  logic [NWW-1:0] wr_wid_q[$];
  logic [UW-1:0] wr_uuid_q[$];
  int rsp_cyc_q[$];
  int rise_q[$];
  logic [NT*32-1:0] rsp_data_q[$];
  logic [NT-1:0] rsp_tmask_q[$];
  logic [NWW-1:0] rsp_wid_q[$];
  logic [UW-1:0] rsp_uuid_q[$];
  int acc_cyc_q[$];
  int stamp_cyc_q[$];
  logic rsp_v_prev = 1'b0;
  logic src_pop = 1'b0;
  int fetch_model = 0;

  always @(negedge clk) begin
    if (csr_write_enable) begin
      wr_cyc_q.push_back(cyc);
      wr_tmask_q.push_back(csr_write_tmask);
      wr_data_q.push_back(csr_write_data);
      wr_wid_q.push_back(csr_write_wid);
      wr_uuid_q.push_back(csr_write_uuid);
    end
    if (rsp_valid && !rsp_v_prev) rise_q.push_back(cyc);
    if (rsp_valid && rsp_ready) begin
      rsp_cyc_q.push_back(cyc);
      rsp_data_q.push_back(rsp_data);
      rsp_tmask_q.push_back(rsp_tmask);
      rsp_wid_q.push_back(rsp_wid);
      rsp_uuid_q.push_back(rsp_uuid);
    end
    if (req_valid && req_ready) acc_cyc_q.push_back(cyc);
    if (stamp_valid && stamp_ready) stamp_cyc_q.push_back(cyc);
    if (!reset) fetch_model <= 0;
    else if (req_valid && req_ready) fetch_model <= fetch_model + 1;
    rsp_v_prev <= rsp_valid;
    src_pop <= stamp_valid && stamp_ready;
  end

  // ---------------- stamp source ----------------
  logic [SW-1:0] src_q[$];
  int gap_pct = 0;
  bit done_when_empty = 1'b0;

  initial forever begin
    @(posedge clk);
    #1;
    if (src_pop && src_q.size() > 0) begin
      void'(src_q.pop_front());
      stamp_valid = 1'b0;
    end
    if (src_q.size() == 0) stamp_valid = 1'b0;
    else if (!stamp_valid) stamp_valid = ($urandom_range(0, 99) >= gap_pct);
    stamp_data = (src_q.size() > 0) ? src_q[0] : '0;
    stamp_done = done_when_empty && (src_q.size() == 0);
  end

  // ---------------- reference model ----------------
  // Stamps go to active lanes in ascending order until either the lanes or
  // the stamps run out.
  function automatic void model_req(input logic [NT-1:0] tm, input logic [SW-1:0] st[$],
                                    output logic [NT-1:0] f, output logic [NT*SW-1:0] d);
    int idx = 0;
    f = '0;
    d = '0;
    for (int i = 0; i < NT; i++) begin
      if (tm[i] && idx < st.size()) begin
        f[i] = 1'b1;
        d[i*SW +: SW] = st[idx];
        idx++;
      end
    end
  endfunction

  function automatic logic [NT*32-1:0] rsp_of(input logic [NT-1:0] f);
    logic [NT*32-1:0] r = '0;
    for (int i = 0; i < NT; i++) r[i*32 +: 32] = 32'(f[i]);
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    wr_cyc_q.delete(); wr_tmask_q.delete(); wr_data_q.delete();
    wr_wid_q.delete(); wr_uuid_q.delete();
    rsp_cyc_q.delete(); rise_q.delete(); rsp_data_q.delete();
    rsp_tmask_q.delete(); rsp_wid_q.delete(); rsp_uuid_q.delete();
    acc_cyc_q.delete(); stamp_cyc_q.delete();
  endtask

  task automatic issue(input logic [NWW-1:0] wid, input logic [NT-1:0] tm,
                       input logic [UW-1:0] uuid, output int acc);
    req_wid = wid; req_tmask = tm; req_uuid = uuid; req_valid = 1'b1;
    acc = -1;
    for (int t = 0; t < TO; t++) begin
      @(negedge clk);
      if (req_ready) begin
        acc = cyc;
        break;
      end
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < TO; t++) begin
      if (rsp_cyc_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic run_one(input logic [NWW-1:0] wid, input logic [NT-1:0] tm,
                         input logic [UW-1:0] uuid, input logic [SW-1:0] st[$],
                         input bit dwe, output int acc, output bit ok);
    clear_logs();
    src_q.delete();
    foreach (st[i]) src_q.push_back(st[i]);
    done_when_empty = dwe;
    tick();
    issue(wid, tm, uuid, acc);
    wait_rsp(1, ok);
  endtask

  function automatic logic [UW-1:0] rand_uuid();
    logic [63:0] v = {$urandom(), $urandom()};
    return v[UW-1:0];
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    vectors++;
    if ({req_ready, stamp_ready, csr_write_enable, rsp_valid} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b expected 0000", {req_ready, stamp_ready, csr_write_enable, rsp_valid});
    end
    vectors++;
    if ({csr_write_data, rsp_data, csr_write_tmask, rsp_tmask, rsp_uuid} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: data outputs not zero");
    end
    tick();
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release_same: req_ready=%b expected 0", req_ready);
    end
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_next: req_ready=%b expected 1", req_ready);
    end
  endtask

  task automatic test_full();
    logic [SW-1:0] st[$];
    logic [NT-1:0] f;
    logic [NT*SW-1:0] d;
    logic [UW-1:0] u;
    int n;
    bit ok;
    st = '{64'hA, 64'hB, 64'hC, 64'hD};
    u = rand_uuid();
    gap_pct = 0;
    run_one(2'd2, 4'b1111, u, st, 1'b0, n, ok);
    model_req(4'b1111, st, f, d);
    vectors++;
    if (!ok || n < 0 || wr_cyc_q.size() != 1) begin
      miscompares++;
      $display("FAIL full_done: ok=%0d acc=%0d writes=%0d expected 1 write", ok, n, wr_cyc_q.size());
    end else begin
      vectors++;
      if (wr_cyc_q[0] != n + 5 || rise_q[0] != n + 6) begin
        miscompares++;
        $display("FAIL full_lat: write at +%0d rsp at +%0d expected +5 +6", wr_cyc_q[0] - n, rise_q[0] - n);
      end
      vectors++;
      if (stamp_cyc_q.size() != 4 || stamp_cyc_q[0] != n + 1 || stamp_cyc_q[3] != n + 4) begin
        miscompares++;
        $display("FAIL full_stamps: %0d stamps consumed, expected 4 at +1..+4", stamp_cyc_q.size());
      end
      vectors++;
      if (wr_tmask_q[0] !== f || wr_data_q[0] !== d || wr_wid_q[0] !== 2'd2 || wr_uuid_q[0] !== u) begin
        miscompares++;
        $display("FAIL full_write: tmask %b data %h expected %b %h", wr_tmask_q[0], wr_data_q[0], f, d);
      end
      vectors++;
      if (rsp_data_q[0] !== rsp_of(4'b1111) || rsp_tmask_q[0] !== 4'b1111 || rsp_uuid_q[0] !== u) begin
        miscompares++;
        $display("FAIL full_rsp: data %h tmask %b expected %h 1111", rsp_data_q[0], rsp_tmask_q[0], rsp_of(4'b1111));
      end
    end
  endtask

  task automatic test_sparse();
    logic [SW-1:0] st[$];
    logic [NT-1:0] f;
    logic [NT*SW-1:0] d;
    int n;
    bit ok;
    st = '{64'h11, 64'h22};
    run_one(2'd1, 4'b1010, 44'h123, st, 1'b0, n, ok);
    model_req(4'b1010, st, f, d);
    vectors++;
    if (!ok || wr_cyc_q.size() != 1) begin
      miscompares++;
      $display("FAIL sparse_done: ok=%0d writes=%0d expected 1", ok, wr_cyc_q.size());
    end else begin
      vectors++;
      if (wr_tmask_q[0] !== 4'b1010 || wr_data_q[0] !== d) begin
        miscompares++;
        $display("FAIL sparse_write: tmask %b data %h expected 1010 %h", wr_tmask_q[0], wr_data_q[0], d);
      end
      vectors++;
      if (wr_cyc_q[0] != n + 3 || rise_q[0] != n + 4) begin
        miscompares++;
        $display("FAIL sparse_lat: write +%0d rsp +%0d expected +3 +4", wr_cyc_q[0] - n, rise_q[0] - n);
      end
      vectors++;
      if (rsp_data_q[0] !== rsp_of(f)) begin
        miscompares++;
        $display("FAIL sparse_rsp: data %h expected %h", rsp_data_q[0], rsp_of(f));
      end
    end
  endtask

  task automatic test_early_done();
    logic [SW-1:0] st[$];
    logic [NT-1:0] f;
    logic [NT*SW-1:0] d;
    int n;
    bit ok;
    st = '{64'h5};
    run_one(2'd3, 4'b1111, 44'h77, st, 1'b1, n, ok);
    model_req(4'b1111, st, f, d);
    vectors++;
    if (!ok || wr_cyc_q.size() != 1) begin
      miscompares++;
      $display("FAIL early_done: ok=%0d writes=%0d expected 1", ok, wr_cyc_q.size());
    end else begin
      vectors++;
      if (wr_tmask_q[0] !== 4'b0001 || wr_data_q[0] !== d || wr_cyc_q[0] != n + 3) begin
        miscompares++;
        $display("FAIL early_write: tmask %b at +%0d expected 0001 at +3", wr_tmask_q[0], wr_cyc_q[0] - n);
      end
      vectors++;
      if (rsp_data_q[0] !== rsp_of(f) || rsp_tmask_q[0] !== 4'b1111) begin
        miscompares++;
        $display("FAIL early_rsp: data %h tmask %b expected %h 1111", rsp_data_q[0], rsp_tmask_q[0], rsp_of(f));
      end
    end
  endtask

  task automatic test_done_at_req();
    logic [SW-1:0] st[$];
    int n;
    bit ok;
    st.delete();
    run_one(2'd0, 4'b1111, 44'h9, st, 1'b1, n, ok);
    vectors++;
    if (!ok || wr_cyc_q.size() != 0) begin
      miscompares++;
      $display("FAIL done_req: ok=%0d writes=%0d expected 0", ok, wr_cyc_q.size());
    end else begin
      vectors++;
      if (rsp_data_q[0] !== '0 || rsp_tmask_q[0] !== 4'b1111) begin
        miscompares++;
        $display("FAIL done_req_rsp: data %h tmask %b expected 0 1111", rsp_data_q[0], rsp_tmask_q[0]);
      end
      vectors++;
      if (rise_q[0] < n + 2 || rise_q[0] > n + 3) begin
        miscompares++;
        $display("FAIL done_req_lat: rsp at +%0d expected +2..+3", rise_q[0] - n);
      end
    end
  endtask

  task automatic test_zero_tmask();
    logic [SW-1:0] st[$];
    int n;
    bit ok;
    st = '{64'hEE};
    run_one(2'd1, 4'b0000, 44'h5A, st, 1'b0, n, ok);
    vectors++;
    if (!ok || wr_cyc_q.size() != 0 || stamp_cyc_q.size() != 0) begin
      miscompares++;
      $display("FAIL zero_tm: ok=%0d writes=%0d stamps=%0d expected 0 0", ok, wr_cyc_q.size(), stamp_cyc_q.size());
    end else begin
      vectors++;
      if (rise_q[0] != n + 2 || rsp_data_q[0] !== '0 || rsp_uuid_q[0] !== 44'h5A) begin
        miscompares++;
        $display("FAIL zero_tm_rsp: rsp at +%0d data %h expected +2 0", rise_q[0] - n, rsp_data_q[0]);
      end
    end
    src_q.delete();
    tick();
  endtask

  task automatic test_backpressure();
    logic [SW-1:0] st[$];
    logic [NT-1:0] f;
    logic [NT*SW-1:0] d;
    int n;
    bit ok;
    clear_logs();
    st = '{64'h101, 64'h102, 64'h103, 64'h104, 64'h201, 64'h202};
    src_q.delete();
    foreach (st[i]) src_q.push_back(st[i]);
    done_when_empty = 1'b0;
    gap_pct = 0;
    rsp_ready = 1'b0;
    tick();
    issue(2'd1, 4'b1111, 44'hAAA, n);
    req_wid = 2'd3; req_tmask = 4'b0011; req_uuid = 44'hBBB; req_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < TO; t++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL bp_rsp: no rsp_valid within %0d cycles", TO);
    end
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_wid !== 2'd1 || rsp_uuid !== 44'hAAA ||
          rsp_data !== rsp_of(4'b1111) || req_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold%0d: valid %b wid %0d uuid %h data %h req_ready %b", c,
                 rsp_valid, rsp_wid, rsp_uuid, rsp_data, req_ready);
      end
    end
    tick();
    rsp_ready = 1'b1;
    for (int t = 0; t < TO && acc_cyc_q.size() < 2; t++) tick();
    req_valid = 1'b0;
    vectors++;
    if (acc_cyc_q.size() < 2 || rsp_cyc_q.size() < 1 || acc_cyc_q[1] != rsp_cyc_q[0] + 1) begin
      miscompares++;
      $display("FAIL bp_next_acc: second request not accepted the cycle after rsp handshake");
    end
    wait_rsp(2, ok);
    model_req(4'b0011, '{64'h201, 64'h202}, f, d);
    vectors++;
    if (!ok || wr_data_q.size() != 2 || wr_tmask_q[1] !== f || wr_data_q[1] !== d || wr_wid_q[1] !== 2'd3) begin
      miscompares++;
      $display("FAIL bp_second: ok=%0d writes=%0d", ok, wr_data_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [NT-1:0] tm[3];
    logic [SW-1:0] st[3][$];
    logic [NT-1:0] f;
    logic [NT*SW-1:0] d;
    int acc[3];
    bit ok;
    clear_logs();
    src_q.delete();
    done_when_empty = 1'b0;
    gap_pct = 0;
    for (int r = 0; r < 3; r++) begin
      tm[r] = NT'($urandom_range(1, 15));
      for (int j = 0; j < $countones(tm[r]); j++) begin
        st[r].push_back({$urandom(), $urandom()});
        src_q.push_back(st[r][j]);
      end
    end
    tick();
    for (int r = 0; r < 3; r++) issue(NWW'(r), tm[r], 44'(r + 16), acc[r]);
    wait_rsp(3, ok);
    for (int r = 1; r < 3; r++) begin
      vectors++;
      if (acc[r] - acc[r-1] != $countones(tm[r-1]) + 3) begin
        miscompares++;
        $display("FAIL b2b_spacing%0d: spacing %0d expected %0d", r, acc[r] - acc[r-1], $countones(tm[r-1]) + 3);
      end
    end
    for (int r = 0; r < 3; r++) begin
      model_req(tm[r], st[r], f, d);
      vectors++;
      if (!ok || wr_data_q.size() != 3 || wr_tmask_q[r] !== f || wr_data_q[r] !== d || wr_wid_q[r] !== NWW'(r)) begin
        miscompares++;
        $display("FAIL b2b_write%0d: writes=%0d", r, wr_data_q.size());
      end
    end
  endtask

  task automatic test_random();
    logic [NT*32-1:0] exp_q[$];
    logic [SW-1:0] st[$];
    logic [NT-1:0] tm, f;
    logic [NT*SW-1:0] d;
    logic [NWW-1:0] w;
    logic [UW-1:0] u;
    logic [NT*32-1:0] e;
    int n, nst;
    bit ok;
    gap_pct = 30;
    for (int it = 0; it < 20; it++) begin
      tm = NT'($urandom_range(0, 15));
      w = NWW'($urandom_range(0, 3));
      u = rand_uuid();
      nst = $urandom_range(0, $countones(tm) + 1);
      st.delete();
      for (int j = 0; j < nst; j++) st.push_back({$urandom(), $urandom()});
      run_one(w, tm, u, st, 1'b1, n, ok);
      model_req(tm, st, f, d);
      exp_q.push_back(rsp_of(f));
      vectors++;
      if (!ok || wr_cyc_q.size() != ((f != '0) ? 1 : 0)) begin
        miscompares++;
        $display("FAIL rnd%0d_count: ok=%0d writes=%0d tm=%b nst=%0d", it, ok, wr_cyc_q.size(), tm, nst);
        void'(exp_q.pop_front());
      end else begin
        if (f != '0) begin
          vectors++;
          if (wr_tmask_q[0] !== f || wr_data_q[0] !== d || wr_wid_q[0] !== w ||
              wr_uuid_q[0] !== u || rise_q[0] != wr_cyc_q[0] + 1) begin
            miscompares++;
            $display("FAIL rnd%0d_write: tmask %b data %h expected %b %h", it, wr_tmask_q[0], wr_data_q[0], f, d);
          end
        end
        e = exp_q.pop_front();
        vectors++;
        if (rsp_data_q[0] !== e || rsp_tmask_q[0] !== tm || rsp_wid_q[0] !== w || rsp_uuid_q[0] !== u) begin
          miscompares++;
          $display("FAIL rnd%0d_rsp: data %h tmask %b expected %h %b", it, rsp_data_q[0], rsp_tmask_q[0], e, tm);
        end
      end
      src_q.delete();
      tick();
      tick();
    end
    gap_pct = 0;
  endtask

  task automatic test_reset_mid();
    logic [SW-1:0] st[$];
    logic [NT-1:0] f;
    logic [NT*SW-1:0] d;
    int n;
    bit ok;
    clear_logs();
    src_q.delete();
    src_q.push_back(64'h31);
    src_q.push_back(64'h32);
    done_when_empty = 1'b0;
    tick();
    issue(2'd2, 4'b1111, 44'hC0, n);
    for (int t = 0; t < TO && stamp_cyc_q.size() < 2; t++) tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({stamp_ready, req_ready, rsp_valid, csr_write_enable} !== 4'b0000) begin
      miscompares++;
      $display("FAIL rstmid_ctrl: got %b expected 0000", {stamp_ready, req_ready, rsp_valid, csr_write_enable});
    end
    tick();
    reset = 1'b1;
    repeat (4) tick();
    vectors++;
    if (stamp_cyc_q.size() != 2 || wr_cyc_q.size() != 0 || rsp_cyc_q.size() != 0) begin
      miscompares++;
      $display("FAIL rstmid_drop: stamps=%0d writes=%0d rsps=%0d expected 2 0 0",
               stamp_cyc_q.size(), wr_cyc_q.size(), rsp_cyc_q.size());
    end
    st = '{64'h41, 64'h42};
    run_one(2'd0, 4'b0110, 44'hC1, st, 1'b0, n, ok);
    model_req(4'b0110, st, f, d);
    vectors++;
    if (!ok || wr_cyc_q.size() != 1 || wr_data_q[0] !== d || rsp_data_q[0] !== rsp_of(f)) begin
      miscompares++;
      $display("FAIL rstmid_fresh: ok=%0d writes=%0d", ok, wr_cyc_q.size());
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_full();
    test_sparse();
    test_early_done();
    test_done_at_req();
    test_zero_tmask();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef RASTER_PACKER_PERF_EN
    @(negedge clk);
    vectors++;
    if (perf_fetches !== 32'(fetch_model)) begin
      miscompares++;
      $display("FAIL perf_fetches: got %0d expected %0d", perf_fetches, fetch_model);
    end
`endif
    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
